mem_arbiter: RTL and testbench

- Shares one single-port data memory between NCORES processor cores in the multicore build.
- Each core raises a read or write request with its 8-bit data address and write data, then stalls until it receives an acq pulse.
- Requests are granted round-robin, one access at a time.
- The arbiter drives the memory port and returns read data to the granted core.

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NCORES cores.
// Each granted access runs IDLE -> ACCESS (MEM_LAT+1 cycles) -> ACK (one acq pulse).
module mem_arbiter #(
  parameter int NCORES  = 4,
  parameter int MEM_LAT = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NCORES-1:0]   req_rd,
  input  logic [NCORES-1:0]   req_wr,
  input  logic [8*NCORES-1:0] core_addr,
  input  logic [8*NCORES-1:0] core_wdata,
  output logic [NCORES-1:0]   acq,
  output logic [7:0]          core_rdata,
  output logic [7:0]          mem_addr,
  output logic [7:0]          mem_wdata,
  output logic                mem_we,
  input  logic [7:0]          mem_rdata,
  output logic                busy,
  output logic [2:0]          grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  rr_ptr;
  logic [2:0]  lat_cnt;
  logic        wr_q;
  logic        lat_done;

  logic        any_req;
  logic [2:0]  win;
  logic [3:0]  cand_sum;
  logic [7:0]  req_v;
  logic [7:0]  wr_v;
  logic [7:0]  addr_arr  [8];
  logic [7:0]  wdata_arr [8];

  // Per-core request/address/data unpacked into fixed 8-entry tables so the
  // 3-bit grant index selects them without width juggling.
  always_comb begin
    req_v = '0;
    wr_v  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      addr_arr[i]  = '0;
      wdata_arr[i] = '0;
    end
    for (int unsigned i = 0; i < NCORES; i++) begin
      req_v[i]     = req_rd[i] | req_wr[i];
      wr_v[i]      = req_wr[i];
      addr_arr[i]  = core_addr[8*i +: 8];
      wdata_arr[i] = core_wdata[8*i +: 8];
    end
  end

  // First requester at or after rr_ptr, wrapping modulo NCORES.
  always_comb begin
    any_req  = 1'b0;
    win      = '0;
    cand_sum = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      cand_sum = {1'b0, rr_ptr} + 4'(i);
      if (cand_sum >= 4'(NCORES)) begin
        cand_sum = cand_sum - 4'(NCORES);
      end
      if (!any_req && req_v[cand_sum[2:0]]) begin
        any_req = 1'b1;
        win     = cand_sum[2:0];
      end
    end
  end

  assign lat_done = (lat_cnt == 3'(MEM_LAT));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    mem_we   = 1'b0;
    acq      = '0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        busy   = 1'b1;
        mem_we = wr_q && (lat_cnt == '0);
        if (lat_done) begin
          state_nx = ACK;
        end
      end
      ACK: begin
        busy = 1'b1;
        for (int unsigned i = 0; i < NCORES; i++) begin
          acq[i] = (grant_id == 3'(i));
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      grant_id   <= '0;
      rr_ptr     <= '0;
      lat_cnt    <= '0;
      wr_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant_id  <= win;
            mem_addr  <= addr_arr[win];
            mem_wdata <= wdata_arr[win];
            wr_q      <= wr_v[win];
            lat_cnt   <= '0;
          end
        end
        ACCESS: begin
          lat_cnt <= lat_cnt + 3'd1;
          if (lat_done && !wr_q) begin
            core_rdata <= mem_rdata;
          end
        end
        ACK: begin
          rr_ptr <= (grant_id == 3'(NCORES - 1)) ? '0 : grant_id + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: the reference model treats the arbiter
// as a work-conserving, one-at-a-time, round-robin server with fixed access duration.
module tb_mem_arbiter;

  localparam int NC  = 4;
  localparam int LAT = 1;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NC-1:0]   req_rd, req_wr;
  logic [8*NC-1:0] core_addr, core_wdata;
  logic [NC-1:0]   acq;
  logic [7:0]      core_rdata, mem_addr, mem_wdata, mem_rdata;
  logic            mem_we, busy;
  logic [2:0]      grant_id;

  logic [NC-1:0]   req_rd0, req_wr0;
  logic [8*NC-1:0] core_addr0, core_wdata0;
  logic [NC-1:0]   acq0;
  logic [7:0]      core_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic            mem_we0, busy0;
  logic [2:0]      grant_id0;

  logic [7:0] mem    [256];
  logic [7:0] mem0   [256];
  logic [7:0] refmem [256];

  exp_t          expq [NC][$];
  logic [NC-1:0] pending;
  logic [NC-1:0] acked;
  int            pending_since [NC];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int ptr, last_acq, we_cnt, busy_cnt;
  logic [7:0] we_addr, we_data;

  mem_arbiter #(.NCORES(NC), .MEM_LAT(LAT)) u_dut (
    .CLK(clk), .RST_N(rst_n), .req_rd(req_rd), .req_wr(req_wr),
    .core_addr(core_addr), .core_wdata(core_wdata), .acq(acq),
    .core_rdata(core_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  mem_arbiter #(.NCORES(NC), .MEM_LAT(0)) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .req_rd(req_rd0), .req_wr(req_wr0),
    .core_addr(core_addr0), .core_wdata(core_wdata0), .acq(acq0),
    .core_rdata(core_rdata0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_we(mem_we0), .mem_rdata(mem_rdata0), .busy(busy0), .grant_id(grant_id0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Memory with one cycle read latency, and a zero-latency one for the second build.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end
  assign mem_rdata0 = mem0[mem_addr0];

  function automatic void check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", name, got, exp, cyc);
    end
  endfunction

  // Monitor: on each acq, derive which core should have won and when, then pop its expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      ptr = 0; last_acq = cyc; we_cnt = 0; busy_cnt = 0;
    end else begin
      if (mem_we) begin
        we_cnt++; we_addr = mem_addr; we_data = mem_wdata;
      end
      if (busy) busy_cnt++;
      if (acq != '0) begin
        int who, dexp, minp, wexp;
        exp_t e;
        who = -1;
        for (int k = NC - 1; k >= 0; k--) if (acq[k]) who = k;
        check("acq_onehot", $countones(acq), 1);
        minp = 1 << 30;
        for (int j = 0; j < NC; j++)
          if (pending[j] && pending_since[j] < minp) minp = pending_since[j];
        dexp = (last_acq + 1 > minp) ? last_acq + 1 : minp;
        wexp = -1;
        for (int k = 0; k < NC; k++) begin
          int j;
          j = (ptr + k) % NC;
          if (wexp < 0 && pending[j] && pending_since[j] <= dexp) wexp = j;
        end
        check("grant_order", who, wexp);
        check("acq_cycle", cyc, dexp + LAT + 2);
        check("grant_id", int'(grant_id), who);
        check("busy_cycles", busy_cnt, LAT + 2);
        check("acq_has_request", int'(expq[who].size() > 0), 1);
        if (expq[who].size() > 0) begin
          e = expq[who].pop_front();
          if (e.wr) begin
            check("we_pulses", we_cnt, 1);
            check("we_addr", int'(we_addr), int'(e.addr));
            check("we_data", int'(we_data), int'(e.wdata));
            refmem[e.addr] = e.wdata;
          end else begin
            check("rd_no_we", we_cnt, 0);
            check("rd_data", int'(core_rdata), int'(e.rdata));
          end
        end
        ptr = (who + 1) % NC;
        last_acq = cyc; we_cnt = 0; busy_cnt = 0;
        acked[who] = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      if (acked[i]) begin
        req_rd[i] = 1'b0; req_wr[i] = 1'b0; pending[i] = 1'b0; acked[i] = 1'b0;
      end
    end
  endtask

  task automatic issue(input int i, input bit rd, input bit wr,
                       input logic [7:0] a, input logic [7:0] wd);
    exp_t e;
    req_rd[i] = rd; req_wr[i] = wr;
    core_addr[i*8 +: 8] = a; core_wdata[i*8 +: 8] = wd;
    pending[i] = 1'b1; pending_since[i] = cyc;
    e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = refmem[a];
    expq[i].push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    while (pending != '0 && n < 80) begin
      step(); n++;
    end
    check("drain_pending", int'(pending), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_rd = '0; req_wr = '0; core_addr = '0; core_wdata = '0;
    req_rd0 = '0; req_wr0 = '0; core_addr0 = '0; core_wdata0 = '0;
    pending = '0; acked = '0;
    for (int a = 0; a < 256; a++) begin
      mem[a] = 8'(a) ^ 8'hA5; refmem[a] = 8'(a) ^ 8'hA5; mem0[a] = 8'h00;
    end
    mem[8'h10] = 8'h5A; refmem[8'h10] = 8'h5A; mem0[8'h7F] = 8'h99;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_acq", int'(acq), 0);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_wdata", int'(mem_wdata), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_core_rdata", int'(core_rdata), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single read from core 2.
    step();
    issue(2, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk); @(negedge clk);
    check("rd_mem_addr", int'(mem_addr), 8'h10);
    check("rd_mem_we", int'(mem_we), 0);
    wait_done();

    // Single write from core 0, then read it back.
    issue(0, 1'b0, 1'b1, 8'h20, 8'hC3);
    wait_done();
    check("mem_written", int'(mem[8'h20]), 8'hC3);
    issue(0, 1'b1, 1'b0, 8'h20, 8'h00);
    wait_done();

    // Read and write together count as a write.
    issue(1, 1'b1, 1'b1, 8'h05, 8'h11);
    wait_done();

    // Request dropped and address changed after grant: access still completes unchanged.
    issue(3, 1'b1, 1'b0, 8'h33, 8'h00);
    step();
    req_rd[3] = 1'b0; core_addr[31:24] = 8'h44;
    wait_done();

    // Abort a write with reset after moving rr_ptr away from zero.
    issue(2, 1'b1, 1'b0, 8'h26, 8'h00);
    wait_done();
    issue(1, 1'b0, 1'b1, 8'h09, 8'hEE);
    @(negedge clk); @(negedge clk);
    check("abort_pre_we", int'(mem_we), 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_we", int'(mem_we), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_acq", int'(acq), 0);
    req_rd = '0; req_wr = '0; pending = '0; acked = '0;
    for (int i = 0; i < NC; i++) expq[i].delete();
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    check("abort_grant_id", int'(grant_id), 0);
    issue(1, 1'b1, 1'b0, 8'h0D, 8'h00);
    issue(3, 1'b1, 1'b0, 8'h0F, 8'h00);
    wait_done();
    check("abort_no_write", int'(mem[8'h09]), 8'h09 ^ 8'hA5);

    // Random traffic: moderate load, then every core requesting continuously.
    for (int phase = 0; phase < 2; phase++) begin
      repeat (phase == 0 ? 300 : 150) begin
        step();
        for (int i = 0; i < NC; i++) begin
          if (!pending[i] && !acked[i] && $urandom_range(99) < (phase == 0 ? 30 : 100)) begin
            int op;
            logic [7:0] a;
            op = int'($urandom_range(2));
            a = (8'($urandom_range(63)) << 2) | 8'(i);
            issue(i, op != 1, op != 0, a, 8'($urandom_range(255)));
          end
        end
      end
      wait_done();
    end
    for (int i = 0; i < NC; i++) check("queue_empty", expq[i].size(), 0);

    // Zero-latency build: core 3 reads 0x7F.
    step();
    req_rd0[3] = 1'b1; core_addr0[31:24] = 8'h7F;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check("lat0_acq", int'(acq0), (t == 2) ? 8 : 0);
      if (t == 2) begin
        check("lat0_rdata", int'(core_rdata0), 8'h99);
        @(posedge clk); #1 req_rd0[3] = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
